// File: rtl/dart_multi_ctrl.sv
// Host-command controller for NUM_SIM simulator channels; replies leave one cycle after the operation ends, config strobes one cycle after each rx word.
// Replies hold until tx_ack; rx words outside IDLE/CONFIG are dropped and flagged. `DART_CTRL_TIMEOUT_EN adds a 65536-cycle abort in CONFIG/TX waits.
module dart_multi_ctrl #(
   parameter int NUM_SIM    = 2,
   parameter int TIME_WIDTH = 10
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [15:0]             rx_word,
   input  logic                    rx_word_valid,
   output logic [15:0]             tx_word,
   output logic                    tx_word_valid,
   input  logic                    tx_ack,
   output logic [NUM_SIM-1:0]      sim_reset,
   output logic [NUM_SIM-1:0]      sim_enable,
   output logic                    stop_injection,
   output logic [TIME_WIDTH-1:0]   sim_time,
   output logic                    sim_time_tick,
   input  logic [NUM_SIM-1:0]      sim_quiescent,
   input  logic [NUM_SIM-1:0]      sim_error,
   output logic [15:0]             config_word,
   output logic [NUM_SIM-1:0]      config_valid,
   input  logic [NUM_SIM*16-1:0]   stats_word,
   output logic [NUM_SIM-1:0]      stats_shift,
   output logic                    control_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_RESET, S_CONFIG, S_RUN, S_DRAIN, S_TX, S_TXWAIT, S_SHIFT
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [NUM_SIM-1:0]      sel_q, sel_d;
   logic [3:0]              ch_q, ch_d;
   logic                    stats_q, stats_d;
   logic [15:0]             reply_q, reply_d;
   logic [TIME_WIDTH-1:0]   time_q, time_d;
   logic [15:0]             cfg_word_q, cfg_word_d;
   logic [NUM_SIM-1:0]      cfg_vld_q, cfg_vld_d;
   logic                    err_q, err_d;
   logic                    por_q, por_d;
`ifdef DART_CTRL_TIMEOUT_EN
   logic [15:0]             to_q, to_d;
   logic                    waiting;
`endif

   logic [3:0]              opcode, ch;
   logic [7:0]              arg;
   logic                    bcast, ch_ok, all_quiet, err_set, err_clr;
   logic [NUM_SIM-1:0]      rx_sel, sim_enable_int;
   logic [5:0]              q6, e6;
   logic [15:0]             slice;

   always_comb begin
      opcode = rx_word[15:12];
      ch     = rx_word[11:8];
      arg    = rx_word[7:0];
      bcast  = (ch == 4'hF);
      ch_ok  = bcast || (int'(ch) < NUM_SIM);
      rx_sel = '0;
      slice  = '0;
      for (int i = 0; i < NUM_SIM; i++) begin
         rx_sel[i] = bcast || (int'(ch) == i);
         if (int'(ch_q) == i) slice = stats_word[16*i +: 16];
      end
      q6 = '0;
      e6 = '0;
      q6[NUM_SIM-1:0] = sim_quiescent;
      e6[NUM_SIM-1:0] = sim_error;
      all_quiet = &(sim_quiescent | ~sel_q);
      sim_enable_int = (state_q == S_RUN || state_q == S_DRAIN) ? sel_q : '0;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      ch_d       = ch_q;
      stats_d    = stats_q;
      reply_d    = reply_q;
      cfg_word_d = cfg_word_q;
      cfg_vld_d  = '0;
      err_set    = 1'b0;
      err_clr    = 1'b0;
      por_d      = 1'b0;
      time_d     = time_q;
      if (|sim_enable_int) time_d = time_q + {{(TIME_WIDTH-1){1'b0}}, 1'b1};

      case (state_q)
         S_IDLE: begin
            if (rx_word_valid) begin
               if (opcode > 4'd6) begin
                  err_set = 1'b1;
               end else if (opcode >= 4'd1 && opcode <= 4'd4) begin
                  if (!ch_ok || (opcode == 4'd4 && bcast)) begin
                     err_set = 1'b1;
                  end else begin
                     sel_d = rx_sel;
                     ch_d  = ch;
                     cnt_d = arg;
                     if (opcode == 4'd1) begin
                        state_d = S_RESET;
                        cnt_d   = 8'd3;
                        time_d  = '0;
                     end else if (arg != 8'd0) begin
                        if (opcode == 4'd2) state_d = S_CONFIG;
                        else if (opcode == 4'd3) state_d = S_RUN;
                        else begin
                           state_d = S_TX;
                           stats_d = 1'b1;
                        end
                     end
                  end
               end else if (opcode == 4'd5) begin
                  reply_d = {4'h5, q6, e6};
                  stats_d = 1'b0;
                  state_d = S_TX;
               end else if (opcode == 4'd6) begin
                  err_clr = 1'b1;
               end
            end
         end
         S_RESET: begin
            if (cnt_q == 8'd0) state_d = S_IDLE;
            else cnt_d = cnt_q - 8'd1;
         end
         S_CONFIG: begin
            if (rx_word_valid) begin
               cfg_word_d = rx_word;
               cfg_vld_d  = sel_q;
               cnt_d      = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = S_IDLE;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = S_DRAIN;
         end
         // Drain keeps channels enabled for at least one cycle, leaving once all selected report quiet.
         S_DRAIN: begin
            if (all_quiet) begin
               reply_d = {4'hA, ch_q, 8'h00};
               stats_d = 1'b0;
               state_d = S_TX;
            end
         end
         S_TX, S_TXWAIT: begin
            if (tx_ack) state_d = stats_q ? S_SHIFT : S_IDLE;
            else state_d = S_TXWAIT;
         end
         S_SHIFT: begin
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? S_IDLE : S_TX;
         end
         default: state_d = S_IDLE;
      endcase

      if (rx_word_valid && state_q != S_IDLE && state_q != S_CONFIG) err_set = 1'b1;

`ifdef DART_CTRL_TIMEOUT_EN
      waiting = (state_q == S_CONFIG && !rx_word_valid) ||
                ((state_q == S_TX || state_q == S_TXWAIT) && !tx_ack);
      to_d = waiting ? to_q + 16'd1 : 16'd0;
      if (waiting && to_q == 16'hFFFF) begin
         state_d = S_IDLE;
         err_set = 1'b1;
         to_d    = 16'd0;
      end
`endif

      err_d = err_set | (err_q & ~err_clr);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sel_q      <= '0;
         ch_q       <= '0;
         stats_q    <= 1'b0;
         reply_q    <= '0;
         time_q     <= '0;
         cfg_word_q <= '0;
         cfg_vld_q  <= '0;
         err_q      <= 1'b0;
         por_q      <= 1'b1;
`ifdef DART_CTRL_TIMEOUT_EN
         to_q       <= '0;
`endif
      end else if (enable) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         ch_q       <= ch_d;
         stats_q    <= stats_d;
         reply_q    <= reply_d;
         time_q     <= time_d;
         cfg_word_q <= cfg_word_d;
         cfg_vld_q  <= cfg_vld_d;
         err_q      <= err_d;
         por_q      <= por_d;
`ifdef DART_CTRL_TIMEOUT_EN
         to_q       <= to_d;
`endif
      end
   end

   always_comb begin
      sim_enable     = sim_enable_int;
      sim_time_tick  = |sim_enable_int;
      stop_injection = (state_q == S_DRAIN);
      sim_reset      = por_q ? {NUM_SIM{1'b1}} : ((state_q == S_RESET) ? sel_q : '0);
      stats_shift    = (state_q == S_SHIFT) ? sel_q : '0;
      tx_word_valid  = (state_q == S_TX || state_q == S_TXWAIT);
      tx_word        = !tx_word_valid ? 16'h0000 : (stats_q ? slice : reply_q);
      sim_time       = time_q;
      config_word    = cfg_word_q;
      config_valid   = cfg_vld_q;
      control_error  = err_q;
   end

endmodule
